// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_W_DEFAULT = 8;

  // Iteration counter width for a given operand width (WIDTH >= 2).
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, try to
// subtract the divisor, keep the difference only if it did not go negative.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_nxt,
  output logic             q_bit
);

  logic [WIDTH:0] rs;
  logic [WIDTH:0] t;

  // Trial subtraction at WIDTH+1 bits; MSB of t is the borrow/sign.
  always_comb begin
    rs    = {r[WIDTH-1:0], q_msb};
    t     = rs - {1'b0, d};
    q_bit = ~t[WIDTH];
    r_nxt = q_bit ? t : rs;
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned divider, one restoring step per clock, start/done
// handshake with results held until the next accepted start.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_nxt;
  logic             q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r     (r),
    .q_msb (q[WIDTH-1]),
    .d     (d),
    .r_nxt (r_nxt),
    .q_bit (q_bit)
  );

  // FSM, iteration registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      q           <= '0;
      d           <= '0;
      r           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor != '0) begin
              q           <= dividend;
              d           <= divisor;
              r           <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state       <= RUN;
            end else begin
              // Zero divisor bypasses the iteration entirely.
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end
          end
        end
        RUN: begin
          r   <= r_nxt;
          q   <= {q[WIDTH-2:0], q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            quotient  <= {q[WIDTH-2:0], q_bit};
            remainder <= r_nxt[WIDTH-1:0];
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (WIDTH = 8).
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are looked at 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and run until done (bounded). Latency is
  // the cycle index of done relative to the start cycle, -1 on timeout.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cnt, output logic held,
                        output logic busy_at_done);
    logic [W-1:0] pq, pr;
    pq = quotient;
    pr = remainder;
    held = 1'b1;
    busy_cnt = 0;
    busy_at_done = 1'b0;
    lat = -1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        lat = c;
        busy_at_done = busy;
        break;
      end
      if (quotient !== pq || remainder !== pr) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    n_cmp++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_bad++;
      $display("FAIL reset: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int busy_bad = 0;
    int done_cyc = -1;
    int done_cnt = 0;
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start = 1'b0;
      if (busy !== ((c >= 1 && c <= 8) ? 1'b1 : 1'b0)) busy_bad++;
      if (done) begin
        done_cnt++;
        done_cyc = c;
        n_cmp++;
        if (quotient !== 8'd14 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
          n_bad++;
          $display("FAIL basic_result: got q=%0d r=%0d dz=%b, want q=14 r=2 dz=0",
                   quotient, remainder, div_by_zero);
        end
      end
    end
    n_cmp++;
    if (done_cyc !== 9 || done_cnt !== 1) begin
      n_bad++;
      $display("FAIL basic_latency: got done cycle %0d count %0d, want cycle 9 count 1",
               done_cyc, done_cnt);
    end
    n_cmp++;
    if (busy_bad !== 0) begin
      n_bad++;
      $display("FAIL basic_busy: got %0d wrong busy cycles, want 0", busy_bad);
    end
  endtask

  task automatic test_edges();
    logic [W-1:0] ta [4] = '{8'd255, 8'd255, 8'd0,  8'd5};
    logic [W-1:0] tb [4] = '{8'd1,   8'd255, 8'd13, 8'd10};
    logic [W-1:0] eq [4] = '{8'd255, 8'd1,   8'd0,  8'd0};
    logic [W-1:0] er [4] = '{8'd0,   8'd0,   8'd0,  8'd5};
    int lat, bc;
    logic held, bd;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], lat, bc, held, bd);
      n_cmp++;
      if (lat !== 9 || quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0) begin
        n_bad++;
        $display("FAIL edge_%0d: %0d/%0d got lat=%0d q=%0d r=%0d dz=%b, want lat=9 q=%0d r=%0d dz=0",
                 i, ta[i], tb[i], lat, quotient, remainder, div_by_zero, eq[i], er[i]);
      end
      tick();
    end
  endtask

  task automatic test_div0();
    int lat, bc;
    logic held, bd;
    run_op(8'd42, 8'd0, lat, bc, held, bd);
    n_cmp++;
    if (lat !== 1 || bc !== 0 || quotient !== 8'hFF || remainder !== 8'd42 || div_by_zero !== 1'b1) begin
      n_bad++;
      $display("FAIL div0: got lat=%0d busy_cycles=%0d q=%0d r=%0d dz=%b, want lat=1 busy=0 q=255 r=42 dz=1",
               lat, bc, quotient, remainder, div_by_zero);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || quotient !== 8'hFF || remainder !== 8'd42 || div_by_zero !== 1'b1) begin
      n_bad++;
      $display("FAIL div0_hold: got done=%b q=%0d r=%0d dz=%b, want done=0 q=255 r=42 dz=1",
               done, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_ignore_start();
    int done_cnt = 0;
    logic [W-1:0] gq = '0, gr = '0;
    dividend = 8'd200; divisor = 8'd3; start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      start = 1'b0;
      if (c == 4) begin
        start = 1'b1; dividend = 8'd9; divisor = 8'd9;
      end
      if (done) begin
        done_cnt++;
        gq = quotient;
        gr = remainder;
      end
    end
    n_cmp++;
    if (done_cnt !== 1 || gq !== 8'd66 || gr !== 8'd2) begin
      n_bad++;
      $display("FAIL ignore_start: got dones=%0d q=%0d r=%0d, want dones=1 q=66 r=2",
               done_cnt, gq, gr);
    end
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    int lat, bc;
    logic held, bd;
    dividend = 8'd77; divisor = 8'd5; start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    n_cmp++;
    if (done_cnt !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: got %0d busy/done cycles after abort, want 0", done_cnt);
    end
    run_op(8'd77, 8'd5, lat, bc, held, bd);
    n_cmp++;
    if (lat !== 9 || quotient !== 8'd15 || remainder !== 8'd2) begin
      n_bad++;
      $display("FAIL reset_mid_rerun: got lat=%0d q=%0d r=%0d, want lat=9 q=15 r=2",
               lat, quotient, remainder);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic held, bd;
    logic [W-1:0] a, b, lq, lr;
    int errs = 0;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom_range(0, 255));
      b = (i % 16 == 3) ? '0 : W'($urandom_range(0, 255));
      run_op(a, b, lat, bc, held, bd);
      n_cmp++;
      if (b == '0) begin
        if (lat !== 1 || quotient !== 8'hFF || remainder !== a || div_by_zero !== 1'b1 || !held) begin
          n_bad++; errs++;
          if (errs < 10)
            $display("FAIL b2b_div0 #%0d: %0d/0 got lat=%0d q=%0d r=%0d dz=%b held=%b, want lat=1 q=255 r=%0d dz=1",
                     i, a, lat, quotient, remainder, div_by_zero, held, a);
        end
      end else begin
        if (lat !== 9 || bc !== 8 || bd !== 1'b0 || div_by_zero !== 1'b0 || !held ||
            (16'(quotient) * 16'(b) + 16'(remainder)) !== 16'(a) || remainder >= b ||
            quotient !== a / b) begin
          n_bad++; errs++;
          if (errs < 10)
            $display("FAIL b2b #%0d: %0d/%0d got lat=%0d busy=%0d q=%0d r=%0d dz=%b held=%b, want lat=9 q=%0d r=%0d dz=0",
                     i, a, b, lat, bc, quotient, remainder, div_by_zero, held, a / b, a % b);
        end
      end
      lq = quotient;
      lr = remainder;
      tick();
      n_cmp++;
      if (quotient !== lq || remainder !== lr || done !== 1'b0 || busy !== 1'b0) begin
        n_bad++; errs++;
        if (errs < 10)
          $display("FAIL b2b_idle_hold #%0d: got q=%0d r=%0d done=%b busy=%b, want q=%0d r=%0d done=0 busy=0",
                   i, quotient, remainder, done, busy, lq, lr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    tick();
    test_edges();
    test_div0();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
